mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one unified mem_system instance between the fetch stage (I-side, read-only) and the
//  memory stage (D-side, read/write). Sits between fetch/memory and mem_system.
//  Sequences one transaction at a time and holds addr/data stable until mem_done.
//  Routes data/err back to the owner, and generates per-side stall/done.
//  D-side has priority, with a starvation bound that guarantees I-side progress.
// PARAMETERS
//  STARVE_MAX  4  consecutive D grants allowed while i_rd is pending before I is forced next
// PORTS
//  clk         in   1   system clock, rising edge
//  rst         in   1   reset, asynchronous, active-low
//  i_rd        in   1   fetch read request (level, held while i_stall)
//  i_addr      in   16  fetch address
//  i_cancel    in   1   fetch redirect; discard any in-flight I result
//  d_rd        in   1   data read request (level)
//  d_wr        in   1   data write request (level; d_rd&d_wr never both 1)
//  d_addr      in   16  data address
//  d_wdata     in   16  data write value
//  mem_dataout in   16  mem_system DataOut
//  mem_done    in   1   mem_system Done (1-cycle pulse)
//  mem_err     in   1   mem_system err
//  mem_addr    out  16  to mem_system Addr
//  mem_datain  out  16  to mem_system DataIn
//  mem_rd      out  1   to mem_system Rd
//  mem_wr      out  1   to mem_system Wr
//  i_instr     out  16  instruction to fetch, valid when i_done
//  i_done      out  1   I transaction complete (1-cycle pulse)
//  i_stall     out  1   I request pending, not completing this cycle
//  i_err       out  1   err while I owns memory
//  d_rdata     out  16  load data, valid when d_done
//  d_done      out  1   D transaction complete (1-cycle pulse)
//  d_stall     out  1   D request pending, not completing this cycle
//  d_err       out  1   err while D owns memory
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, starve_cnt=0, drop=0, latches=0; every output 0.
//  States: IDLE, GNT_I, GNT_D.
//  IDLE -> GNT_D if (d_rd|d_wr) & (~i_rd | starve_cnt<STARVE_MAX).
//       -> GNT_I else if i_rd. Winner's addr/wdata/op are latched at the edge.
//  GNT_x: mem_addr/mem_datain/mem_rd/mem_wr are driven from the latch only. They stay stable
//       until mem_done, then return to IDLE. No back-to-back grant: at least 1 IDLE cycle between.
//  mem_rd=mem_wr=0 in IDLE. Latency is request -> mem op 1 cycle; done equals mem_done (comb).
//  i_done = GNT_I & mem_done & ~drop & ~i_cancel.
//  d_done = GNT_D & mem_done. Data is passed through combinationally.
//  i_stall = i_rd & ~i_done. d_stall = (d_rd|d_wr) & ~d_done.
//  Requester inputs are ignored once latched; a request dropped mid-grant still completes.
//  i_cancel: while in GNT_I, sets drop (sticky to mem_done). The result is suppressed and
//       state returns to IDLE. In IDLE, i_cancel has no effect.
//  starve_cnt: +1 on each D grant with i_rd=1 (saturates at STARVE_MAX); cleared on I grant
//       or when i_rd=0 in IDLE.
//  Simultaneous i_rd & d_* in IDLE with cnt<MAX -> D wins. With cnt==MAX -> I wins.
//  i_err/d_err = mem_err gated by owning GNT state; 0 in IDLE. The error does not end the txn.
//  Widths: starve_cnt is $clog2(STARVE_MAX+1) bits; no arithmetic on addresses.
// STRUCTURE
//  arb_pkg: state encoding (IDLE=2'b00, GNT_I=2'b01, GNT_D=2'b10) and OP_RD/OP_WR constants.
//  One sub-module: arb_starve_cnt (saturating counter, inc/clr/at_max).
//  The FSM, latch and output muxing stay in mem_arbiter.
// TESTING
//  1 i_rd=1, i_addr=16'h0010; mem_done 3 cycles after mem_rd -> i_done 1 cycle, i_instr=dataout,
//    mem_addr=16'h0010 held throughout.
//  2 d_wr=1 (addr 16'h0200, data 16'hBEEF) with i_rd=1 in the same cycle -> GNT_D first,
//    mem_wr=1, mem_datain=BEEF; I granted only after d_done plus 1 IDLE cycle.
//  3 d_rd held continuously with i_rd=1, STARVE_MAX=4 -> exactly 4 D grants, then 1 I grant,
//    then the count restarts.
//  4 i_cancel pulse in GNT_I before mem_done -> no i_done. mem_rd is held to mem_done,
//    then IDLE; a new i_rd is served normally.
//  5 rst low mid GNT_D -> all outputs 0 immediately; after release, state IDLE,
//    and the pending d_rd is re-granted.
//  6 mem_err=1 during GNT_I -> i_err=1, d_err=0; during IDLE -> both 0.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: state encoding and operation codes shared by the memory arbiter.
package arb_pkg;
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] GNT_I = 2'b01;
    localparam logic [1:0] GNT_D = 2'b10;
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, memory-stage and mem_system signals seen by the arbiter.
interface mem_arbiter_if;
    logic        i_rd, i_cancel, d_rd, d_wr, mem_done, mem_err;
    logic [15:0] i_addr, d_addr, d_wdata, mem_dataout;
    logic [15:0] mem_addr, mem_datain, i_instr, d_rdata;
    logic        mem_rd, mem_wr, i_done, i_stall, i_err, d_done, d_stall, d_err;
    modport master (
        input  i_rd, i_addr, i_cancel, d_rd, d_wr, d_addr, d_wdata, mem_dataout, mem_done, mem_err,
        output mem_addr, mem_datain, mem_rd, mem_wr, i_instr, i_done, i_stall, i_err,
               d_rdata, d_done, d_stall, d_err
    );
    modport slave (
        output i_rd, i_addr, i_cancel, d_rd, d_wr, d_addr, d_wdata, mem_dataout, mem_done, mem_err,
        input  mem_addr, mem_datain, mem_rd, mem_wr, i_instr, i_done, i_stall, i_err,
               d_rdata, d_done, d_stall, d_err
    );
endinterface

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating count of D grants taken while a fetch is waiting.
module arb_starve_cnt #(parameter int MAX = 4) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int W = $clog2(MAX + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !at_max) cnt <= cnt + 1'b1;
    assign at_max = cnt == W'(MAX);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_system between fetch (read-only) and memory stage,
// D-side first, with a starvation bound forcing periodic fetch grants.
module mem_arbiter import arb_pkg::*; #(parameter int STARVE_MAX = 4) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.master bus
);
    logic [1:0]  state;
    logic [15:0] lat_addr, lat_wdata;
    logic        lat_op, drop, at_max, d_req, grant_d, grant_i;
    assign d_req   = bus.d_rd | bus.d_wr;
    assign grant_d = (state == IDLE) & d_req & (~bus.i_rd | ~at_max);
    assign grant_i = (state == IDLE) & ~grant_d & bus.i_rd;
    arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
        .clk(clk),
        .rst(rst),
        .inc(grant_d & bus.i_rd),
        .clr(grant_i | ((state == IDLE) & ~bus.i_rd)),
        .at_max(at_max)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_op    <= OP_RD;
            drop      <= 1'b0;
        end else begin
            if (grant_d) begin
                state     <= GNT_D;
                lat_addr  <= bus.d_addr;
                lat_wdata <= bus.d_wdata;
                lat_op    <= bus.d_wr ? OP_WR : OP_RD;
            end else if (grant_i) begin
                state     <= GNT_I;
                lat_addr  <= bus.i_addr;
                lat_wdata <= '0;
                lat_op    <= OP_RD;
            end else if (state != IDLE && bus.mem_done) state <= IDLE;
            // a cancelled fetch stays dropped until its memory op finishes
            drop <= (state == GNT_I) & ~bus.mem_done & (drop | bus.i_cancel);
        end
    assign bus.mem_addr   = lat_addr;
    assign bus.mem_datain = lat_wdata;
    assign bus.mem_rd     = (state == GNT_I) | ((state == GNT_D) & (lat_op == OP_RD));
    assign bus.mem_wr     = (state == GNT_D) & (lat_op == OP_WR);
    assign bus.i_done     = (state == GNT_I) & bus.mem_done & ~drop & ~bus.i_cancel;
    assign bus.d_done     = (state == GNT_D) & bus.mem_done;
    assign bus.i_instr    = bus.i_done ? bus.mem_dataout : '0;
    assign bus.d_rdata    = bus.d_done ? bus.mem_dataout : '0;
    assign bus.i_stall    = rst & bus.i_rd & ~bus.i_done;
    assign bus.d_stall    = rst & d_req & ~bus.d_done;
    assign bus.i_err      = (state == GNT_I) & bus.mem_err;
    assign bus.d_err      = (state == GNT_D) & bus.mem_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, latching, cancel, reset and error routing.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int errors = 0;
    int checks = 0;
    logic exp_i;
    mem_arbiter_if b();
    mem_arbiter #(.STARVE_MAX(4)) dut (.clk(clk), .rst(rst), .bus(b));
    always #5 clk = ~clk;
    task automatic nx;
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask
    task automatic chb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask
    initial begin
        b.i_rd = 0; b.i_addr = 0; b.i_cancel = 0; b.d_rd = 1; b.d_wr = 0;
        b.d_addr = 0; b.d_wdata = 0; b.mem_dataout = 16'hAAAA; b.mem_done = 0; b.mem_err = 0;
        nx; #1;
        chb("rst mem_rd", b.mem_rd, 1'b0);
        chb("rst d_stall", b.d_stall, 1'b0);
        chk("rst mem_addr", b.mem_addr, 16'h0);
        chk("rst d_rdata", b.d_rdata, 16'h0);
        b.d_rd = 0; rst = 1;
        // fetch read, done three cycles after mem_rd
        nx; b.i_rd = 1; b.i_addr = 16'h0010; #1;
        chb("t1 idle mem_rd", b.mem_rd, 1'b0);
        chb("t1 idle stall", b.i_stall, 1'b1);
        nx; #1;
        chb("t1 mem_rd", b.mem_rd, 1'b1);
        chk("t1 addr0", b.mem_addr, 16'h0010);
        b.i_addr = 16'hFFFF;
        nx; #1 chk("t1 addr1", b.mem_addr, 16'h0010);
        nx; #1 chk("t1 addr2", b.mem_addr, 16'h0010);
        nx; b.mem_done = 1; b.mem_dataout = 16'h1234; #1;
        chb("t1 i_done", b.i_done, 1'b1);
        chk("t1 i_instr", b.i_instr, 16'h1234);
        chb("t1 i_stall", b.i_stall, 1'b0);
        chk("t1 addr3", b.mem_addr, 16'h0010);
        nx; b.mem_done = 0; b.i_rd = 0; #1;
        chb("t1 idle after", b.mem_rd, 1'b0);
        chb("t1 done pulse", b.i_done, 1'b0);
        // simultaneous write and fetch: D first
        nx; b.d_wr = 1; b.d_addr = 16'h0200; b.d_wdata = 16'hBEEF; b.i_rd = 1; b.i_addr = 16'h0020; #1;
        chb("t2 d_stall", b.d_stall, 1'b1);
        chb("t2 mem_wr idle", b.mem_wr, 1'b0);
        nx; #1;
        chb("t2 mem_wr", b.mem_wr, 1'b1);
        chb("t2 mem_rd", b.mem_rd, 1'b0);
        chk("t2 addr", b.mem_addr, 16'h0200);
        chk("t2 datain", b.mem_datain, 16'hBEEF);
        b.mem_done = 1; #1;
        chb("t2 d_done", b.d_done, 1'b1);
        chb("t2 d_stall done", b.d_stall, 1'b0);
        chb("t2 i_stall", b.i_stall, 1'b1);
        chb("t2 i_done", b.i_done, 1'b0);
        nx; b.mem_done = 0; b.d_wr = 0; #1;
        chb("t2 gap rd", b.mem_rd, 1'b0);
        chb("t2 gap wr", b.mem_wr, 1'b0);
        nx; #1;
        chb("t2 i mem_rd", b.mem_rd, 1'b1);
        chk("t2 i addr", b.mem_addr, 16'h0020);
        b.mem_done = 1; b.mem_dataout = 16'h4321; #1;
        chk("t2 i_instr", b.i_instr, 16'h4321);
        nx; b.mem_done = 0; b.i_rd = 0;
        // starvation bound: D D D D I D
        nx; b.d_rd = 1; b.d_addr = 16'h0300; b.i_rd = 1; b.i_addr = 16'h0030;
        for (int k = 0; k < 6; k++) begin
            exp_i = (k == 4);
            nx; #1;
            chk($sformatf("t3 addr g%0d", k), b.mem_addr, exp_i ? 16'h0030 : 16'h0300);
            chb($sformatf("t3 mem_rd g%0d", k), b.mem_rd, 1'b1);
            b.mem_done = 1; b.mem_dataout = 16'(k); #1;
            chb($sformatf("t3 i_done g%0d", k), b.i_done, exp_i);
            chb($sformatf("t3 d_done g%0d", k), b.d_done, ~exp_i);
            nx; b.mem_done = 0; #1;
            chb($sformatf("t3 gap g%0d", k), b.mem_rd, 1'b0);
        end
        b.d_rd = 0; b.i_rd = 0;
        // cancel mid-fetch, then a normal fetch with a cancel in IDLE
        nx; b.i_rd = 1; b.i_addr = 16'h0040;
        nx; b.i_cancel = 1; #1;
        chb("t4 mem_rd", b.mem_rd, 1'b1);
        chb("t4 i_done", b.i_done, 1'b0);
        nx; b.i_cancel = 0; #1;
        chb("t4 held rd", b.mem_rd, 1'b1);
        chk("t4 held addr", b.mem_addr, 16'h0040);
        nx; b.mem_done = 1; b.mem_dataout = 16'h5555; #1;
        chb("t4 dropped", b.i_done, 1'b0);
        chk("t4 instr", b.i_instr, 16'h0);
        chb("t4 stall", b.i_stall, 1'b1);
        nx; b.mem_done = 0; b.i_addr = 16'h0044; b.i_cancel = 1; #1;
        chb("t4 idle", b.mem_rd, 1'b0);
        nx; b.i_cancel = 0; #1;
        chk("t4 new addr", b.mem_addr, 16'h0044);
        nx; b.mem_done = 1; b.mem_dataout = 16'h7777; #1;
        chb("t4 new done", b.i_done, 1'b1);
        chk("t4 new instr", b.i_instr, 16'h7777);
        nx; b.mem_done = 0; b.i_rd = 0;
        // async reset during a D grant
        nx; b.d_rd = 1; b.d_addr = 16'h0500;
        nx; #1;
        chb("t5 mem_rd", b.mem_rd, 1'b1);
        chb("t5 d_stall", b.d_stall, 1'b1);
        #2 rst = 0; #1;
        chb("t5 rst mem_rd", b.mem_rd, 1'b0);
        chk("t5 rst addr", b.mem_addr, 16'h0);
        chb("t5 rst d_stall", b.d_stall, 1'b0);
        nx; rst = 1; #1;
        chb("t5 idle rd", b.mem_rd, 1'b0);
        chb("t5 idle stall", b.d_stall, 1'b1);
        nx; #1;
        chk("t5 regrant addr", b.mem_addr, 16'h0500);
        b.mem_done = 1; b.mem_dataout = 16'h6666; #1;
        chb("t5 d_done", b.d_done, 1'b1);
        chk("t5 d_rdata", b.d_rdata, 16'h6666);
        nx; b.mem_done = 0; b.d_rd = 0;
        // error routing
        nx; b.i_rd = 1; b.i_addr = 16'h0060; b.mem_err = 1; #1;
        chb("t6 idle i_err", b.i_err, 1'b0);
        chb("t6 idle d_err", b.d_err, 1'b0);
        nx; #1;
        chb("t6 i_err", b.i_err, 1'b1);
        chb("t6 d_err", b.d_err, 1'b0);
        nx; #1;
        chb("t6 not ended", b.mem_rd, 1'b1);
        b.mem_done = 1; b.mem_dataout = 16'h8888; #1;
        chb("t6 i_done", b.i_done, 1'b1);
        nx; b.mem_done = 0; b.i_rd = 0; b.d_wr = 1; b.d_addr = 16'h0600; b.d_wdata = 16'h1111; #1;
        chb("t6 idle2 i_err", b.i_err, 1'b0);
        nx; #1;
        chb("t6 d side err", b.d_err, 1'b1);
        chb("t6 d side i_err", b.i_err, 1'b0);
        chb("t6 mem_wr", b.mem_wr, 1'b1);
        b.mem_done = 1; #1;
        chb("t6 d_done", b.d_done, 1'b1);
        nx; b.mem_done = 0; b.d_wr = 0; b.mem_err = 0;
        nx;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
